spi_flash_arbiter: RTL and testbench
====================================

// Module: spi_flash_arbiter
//
// PURPOSE
//   Shares one spi_flash_reader command/data interface between N_REQ requesters.
//   - Round-robin arbitration, one read at a time.
//   - Each read runs to completion before the next grant.
//   - Read bytes are steered back to the requester that issued the read.
//   Sits between client blocks (boot loader, pattern fetcher, ...) and the flash reader.
//
// PARAMETERS
//   N_REQ   2   number of requesters, legal range 2..4
//
// PORTS
//   clk          in   1         system clock, same as flash reader
//   rst          in   1         asynchronous reset, active-high
//   req_addr     in   24*N_REQ  flash byte address, requester i at [24*i+:24]
//   req_len      in   16*N_REQ  byte count minus one, requester i at [16*i+:16]
//   req_valid    in   N_REQ     read request; held with addr/len until req_ack
//   req_ack      out  N_REQ     1-cycle pulse: request accepted, addr/len sampled
//   req_done     out  N_REQ     1-cycle pulse: last byte of this read delivered
//   rsp_data     out  8         read byte, shared bus (fr_data passthrough)
//   rsp_valid    out  N_REQ     rsp_data valid for requester i
//   fr_addr      out  24        to reader addr
//   fr_len       out  16        to reader len
//   fr_go        out  1         to reader go
//   fr_rdy       in   1         from reader rdy
//   fr_data      in   8         from reader data
//   fr_valid     in   1         from reader valid
//
// BEHAVIOUR
//   Reader contract:
//     - fr_go is accepted only while fr_rdy=1.
//     - fr_rdy is low the cycle after fr_go.
//     - fr_rdy stays low until the last fr_valid has occurred.
//     - A read returns fr_len+1 bytes.
//     - fr_rdy is 0 out of reset.
//   Reset values: req_ack=0, req_done=0, rsp_valid=0, fr_go=0, fr_addr=0, fr_len=0,
//     grant=0, rr pointer=0, state=IDLE.
//   FSM (2-bit):
//     IDLE : if fr_rdy & |req_valid -> pick winner, register grant -> ISSUE.
//     ISSUE: fr_go=1; req_ack[grant]=1; fr_addr/fr_len registered from grant's inputs
//            the same cycle -> BUSY.
//     BUSY : wait for fr_rdy=1 -> DONE.
//     DONE : req_done[grant]=1; rr pointer <= grant+1 (mod N_REQ) -> IDLE.
//   Arbitration:
//     - Winner is the first set req_valid bit scanning from the rr pointer upward,
//       wrapping past N_REQ-1 to 0.
//     - Only one grant at a time.
//   Latency: req_valid seen in IDLE -> req_ack/fr_go next cycle. Min 2 cycles/read overhead.
//   Data steering:
//     - rsp_data = fr_data combinationally.
//     - rsp_valid = fr_valid ? onehot(grant) : 0.
//     - Bytes arriving outside BUSY are dropped, never steered.
//   Boundary conditions:
//     - req_valid dropped before ack: request silently withdrawn, no ack.
//     - Requester re-asserting req_valid in the DONE cycle: considered in the next IDLE
//       under round-robin; no back-to-back monopoly while another requester is pending.
//     - fr_rdy low in IDLE (reader still flushing or just out of reset): no grant issued.
//     - req_len=0xFFFF: 65536 bytes; no internal length arithmetic, field passed through.
//     - rst mid-read: all state and outputs to reset values at once. The reader shares
//       rst; no req_done is issued for the aborted read.
//
// CONFIGURATION
//   SPI_FLASH_ARB_CHECK_EN defined:
//     - Adds a 17-bit byte counter, cleared in ISSUE, +1 per fr_valid in BUSY.
//     - In DONE, if count != fr_len+1, sets sticky output err (1 bit, reset 0).
//     - err is cleared only by rst.
//     - Port err is present only when the macro is defined.
//   Not defined: no counter, no err port; behaviour otherwise identical.
//
// TESTING
//   1. Single req0, addr=0x010000, len=3 -> one req_ack[0], fr_go 1 cycle later than
//      req_valid, 4 rsp_valid[0] pulses, then req_done[0]; rsp_valid[1] never set.
//   2. req0 and req1 both held, len=0 each -> grants alternate 0,1,0,1 over 4 reads,
//      1 byte and 1 done each.
//   3. req1 re-requests in its DONE cycle while req0 pending -> req0 granted next.
//   4. req0 valid in the reset-release cycle (fr_rdy=0) -> no fr_go until fr_rdy=1.
//   5. Assert rst mid-read (after 2 of 8 bytes) -> all outputs 0 next cycle, no req_done;
//      after release a fresh read completes normally.
//   6. CHECK_EN: model drops one fr_valid on len=7 -> err=1 after DONE; correct read -> err=0.

Source files
------------

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter
//   Shares one spi_flash_reader command/data interface between N_REQ requesters.
//   Requests are granted round-robin, one read at a time. Each read runs to
//   completion before the next grant. Read bytes are steered back to the
//   requester that issued the read.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | reader ready and a request pending -> latch winner, addr and len
//   ISSUE | fr_go and req_ack pulse for the granted requester
//   BUSY  | bytes stream back to the granted requester until fr_rdy returns
//   DONE  | req_done pulse; round-robin pointer moves past the granted requester
//
// Ports
//   clk_i, rst_i    system clock, asynchronous active-high reset
//   req_addr_i      24-bit byte address per requester, requester i at [24*i+:24]
//   req_len_i       byte count minus one per requester, requester i at [16*i+:16]
//   req_valid_i     request, held with addr/len until req_ack_o
//   req_ack_o       1-cycle pulse: request accepted
//   req_done_o      1-cycle pulse: last byte of the read delivered
//   rsp_data_o      read byte (fr_data_i passthrough)
//   rsp_valid_o     rsp_data_o valid for requester i
//   fr_addr_o/fr_len_o/fr_go_o, fr_rdy_i/fr_data_i/fr_valid_i   flash reader side
//   err_o           sticky byte-count mismatch flag (SPI_FLASH_ARB_CHECK_EN only)
//
// Configuration
//   SPI_FLASH_ARB_CHECK_EN  adds a byte counter and the err_o port.

module spi_flash_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [24*N_REQ-1:0]   req_addr_i,
    input  logic [16*N_REQ-1:0]   req_len_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ack_o,
    output logic [N_REQ-1:0]      req_done_o,
    output logic [7:0]            rsp_data_o,
    output logic [N_REQ-1:0]      rsp_valid_o,
    output logic [23:0]           fr_addr_o,
    output logic [15:0]           fr_len_o,
    output logic                  fr_go_o,
    input  logic                  fr_rdy_i,
    input  logic [7:0]            fr_data_i,
    input  logic                  fr_valid_i
`ifdef SPI_FLASH_ARB_CHECK_EN
    ,
    output logic                  err_o
`endif
);

    localparam int PTR_W = (N_REQ > 2) ? 2 : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] rr_q, rr_d;
    logic [23:0]      fr_addr_q, fr_addr_d;
    logic [15:0]      fr_len_q, fr_len_d;

    logic [PTR_W-1:0] winner;
    logic             found;
    logic [N_REQ-1:0] grant_oh;
    logic             issue_go;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return PTR_W'(s);
    endfunction

    // First pending requester at or above the rr pointer, wrapping to 0.
    always_comb begin
        logic [PTR_W-1:0] cand;
        winner = rr_q;
        found  = 1'b0;
        cand   = rr_q;
        for (int k = 0; k < N_REQ; k++) begin
            cand = wrap_idx(rr_q, k);
            if (!found && req_valid_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;

    // A requester that withdraws between the grant and the ack is not
    // acknowledged and the reader is never started.
    assign issue_go = (state_q == S_ISSUE) && req_valid_i[grant_q];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        fr_addr_d = fr_addr_q;
        fr_len_d  = fr_len_q;
        case (state_q)
            S_IDLE: begin
                if (fr_rdy_i && found) begin
                    grant_d   = winner;
                    fr_addr_d = req_addr_i[24*winner +: 24];
                    fr_len_d  = req_len_i[16*winner +: 16];
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = issue_go ? S_BUSY : S_IDLE;
            end
            S_BUSY: begin
                if (fr_rdy_i) state_d = S_DONE;
            end
            S_DONE: begin
                rr_d    = (grant_q == PTR_W'(N_REQ-1)) ? '0 : grant_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            fr_addr_q <= '0;
            fr_len_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            fr_addr_q <= fr_addr_d;
            fr_len_q  <= fr_len_d;
        end
    end

    assign fr_go_o     = issue_go;
    assign fr_addr_o   = fr_addr_q;
    assign fr_len_o    = fr_len_q;
    assign req_ack_o   = issue_go ? grant_oh : '0;
    assign req_done_o  = (state_q == S_DONE) ? grant_oh : '0;
    assign rsp_data_o  = fr_data_i;
    // Bytes outside BUSY belong to no read of ours and are dropped.
    assign rsp_valid_o = ((state_q == S_BUSY) && fr_valid_i) ? grant_oh : '0;

`ifdef SPI_FLASH_ARB_CHECK_EN
    logic [16:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == S_ISSUE) begin
            cnt_d = '0;
        end else if (state_q == S_BUSY && fr_valid_i) begin
            cnt_d = cnt_q + 17'd1;
        end else if (state_q == S_DONE) begin
            if (cnt_q != ({1'b0, fr_len_q} + 17'd1)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_spi_flash_arbiter.sv
module tb_spi_flash_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] req_addr;
    logic [31:0] req_len;
    logic [1:0]  req_valid;
    logic [1:0]  req_ack, req_done, rsp_valid;
    logic [7:0]  rsp_data;
    logic [23:0] fr_addr;
    logic [15:0] fr_len;
    logic        fr_go;
    logic        fr_rdy, fr_valid;
    logic [7:0]  fr_data;
`ifdef SPI_FLASH_ARB_CHECK_EN
    logic        err;
`endif

    spi_flash_arbiter #(.N_REQ(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_addr_i(req_addr), .req_len_i(req_len), .req_valid_i(req_valid),
        .req_ack_o(req_ack), .req_done_o(req_done),
        .rsp_data_o(rsp_data), .rsp_valid_o(rsp_valid),
        .fr_addr_o(fr_addr), .fr_len_o(fr_len), .fr_go_o(fr_go),
        .fr_rdy_i(fr_rdy), .fr_data_i(fr_data), .fr_valid_i(fr_valid)
`ifdef SPI_FLASH_ARB_CHECK_EN
        , .err_o(err)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- flash reader model ----------------
    bit          reader_en = 1'b0;
    bit          go_seen = 1'b0;
    int          drop_idx = -1;
    logic [23:0] rd_addr = '0;
    logic [15:0] rd_len = '0;

    always @(negedge clk) begin
        go_seen = fr_go && fr_rdy;
        if (fr_go && fr_rdy) begin
            rd_addr = fr_addr;
            rd_len  = fr_len;
        end
    end

    initial begin
        bit rd_busy;
        int rd_idx;
        fr_rdy = 1'b0; fr_valid = 1'b0; fr_data = 8'h00;
        rd_busy = 1'b0; rd_idx = 0;
        forever begin
            @(posedge clk); #1;
            if (rst || !reader_en) begin
                fr_rdy = 1'b0; fr_valid = 1'b0; rd_busy = 1'b0;
            end else if (rd_busy) begin
                if (rd_idx <= int'(rd_len)) begin
                    fr_valid = (rd_idx != drop_idx);
                    fr_data  = rd_addr[7:0] + 8'(rd_idx);
                    rd_idx++;
                end else begin
                    fr_valid = 1'b0; fr_rdy = 1'b1; rd_busy = 1'b0;
                end
            end else if (go_seen) begin
                fr_rdy = 1'b0; rd_busy = 1'b1; rd_idx = 0;
            end else begin
                fr_rdy = 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          kind;   // 0 ack, 1 byte, 2 done
        logic [1:0]  vec;
        logic [23:0] addr;
        logic [15:0] len;
        logic [7:0]  data;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         passes = 0;
    int         rem[2] = '{0, 0};
    logic [1:0] drop_mask = 2'b00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    task automatic push_ev(input int kind, input int r, input logic [23:0] a,
                           input logic [15:0] l, input logic [7:0] d);
        ev_t e;
        e.kind = kind; e.vec = 2'b01 << r; e.addr = a; e.len = l; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_read(input int r, input logic [23:0] a, input logic [15:0] l, input int drop);
        push_ev(0, r, a, l, 8'h00);
        for (int i = 0; i <= int'(l); i++)
            if (i != drop) push_ev(1, r, a, l, a[7:0] + 8'(i));
        push_ev(2, r, a, l, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int r, input logic [23:0] a, input logic [15:0] l);
        req_addr[24*r +: 24] = a;
        req_len[16*r +: 16]  = l;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        check({"drain_", name}, 64'(exp_q.size()), 64'd0);
        repeat (4) tick();
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 64'({fr_go, req_ack, req_done, rsp_valid, fr_addr, fr_len}), 64'd0);
    endtask

    // Start a read, let nbytes bytes arrive, then pulse reset mid-read.
    task automatic reset_mid(input int r, input logic [23:0] a, input logic [15:0] l, input int nbytes);
        int n;
        push_ev(0, r, a, l, 8'h00);
        for (int i = 0; i < nbytes; i++) push_ev(1, r, a, l, a[7:0] + 8'(i));
        set_req(r, a, l);
        rem[r] = 1;
        req_valid[r] = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk); #2;
            n++;
        end
        check("mid_read_bytes", 64'(exp_q.size()), 64'd0);
        rst = 1'b1;
        req_valid = 2'b00;
        rem = '{0, 0};
        @(negedge clk);
        check_reset_outputs("reset_mid_read_outputs");
        tick();
        rst = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        int go_cnt;
        bit got;
        rst = 1'b1;
        req_addr = '0; req_len = '0; req_valid = 2'b00;

        fork
            forever begin
                ev_t e;
                @(negedge clk);
                if (!rst && (fr_go || req_ack != 0 || rsp_valid != 0 || req_done != 0)) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'({fr_go, req_ack, rsp_valid, req_done}), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        case (e.kind)
                            0: check("ack", 64'({fr_go, fr_rdy, req_ack, rsp_valid, req_done, fr_addr, fr_len}),
                                     64'({1'b1, 1'b1, e.vec, 2'b00, 2'b00, e.addr, e.len}));
                            1: check("rsp", 64'({fr_go, req_ack, rsp_valid, req_done, rsp_data}),
                                     64'({1'b0, 2'b00, e.vec, 2'b00, e.data}));
                            default: check("done", 64'({fr_go, req_ack, rsp_valid, req_done}),
                                           64'({1'b0, 2'b00, 2'b00, e.vec}));
                        endcase
                    end
                    for (int i = 0; i < 2; i++)
                        if (req_ack[i]) begin
                            rem[i]--;
                            if (rem[i] <= 0) drop_mask[i] = 1'b1;
                        end
                end
            end
            forever begin
                @(posedge clk); #1;
                req_valid = req_valid & ~drop_mask;
                drop_mask = 2'b00;
            end
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state, then req0 valid across reset release with the reader not ready.
        set_req(0, 24'h123456, 16'd1);
        req_valid[0] = 1'b1;
        rem[0] = 1;
        @(negedge clk);
        check_reset_outputs("reset_outputs");
        tick();
        rst = 1'b0;
        go_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (fr_go) go_cnt++;
        end
        check("no_go_while_rdy_low", 64'(go_cnt), 64'd0);
        push_read(0, 24'h123456, 16'd1, -1);
        reader_en = 1'b1;
        drain("rdy_low_release", 60);

        // Single read, fr_go one cycle after req_valid.
        set_req(0, 24'h010000, 16'd3);
        push_read(0, 24'h010000, 16'd3, -1);
        rem[0] = 1;
        req_valid[0] = 1'b1;
        @(negedge clk);
        check("go_not_same_cycle", 64'(fr_go), 64'd0);
        @(negedge clk);
        check("go_next_cycle", 64'(fr_go), 64'd1);
        drain("single", 60);

        // Reset in the middle of reads; no done for the aborted reads.
        reset_mid(0, 24'h0A0010, 16'd7, 2);
        reset_mid(0, 24'h0C0000, 16'hFFFF, 3);
        set_req(1, 24'h0B0020, 16'd2);
        push_read(1, 24'h0B0020, 16'd2, -1);
        rem[1] = 1;
        req_valid[1] = 1'b1;
        drain("after_reset", 60);

        // Both requesters held: grants alternate 0,1,0,1.
        set_req(0, 24'h000100, 16'd0);
        set_req(1, 24'h000200, 16'd0);
        push_read(0, 24'h000100, 16'd0, -1);
        push_read(1, 24'h000200, 16'd0, -1);
        push_read(0, 24'h000100, 16'd0, -1);
        push_read(1, 24'h000200, 16'd0, -1);
        rem = '{2, 2};
        req_valid = 2'b11;
        drain("alternate", 120);

        // req1 re-requests in its DONE cycle while req0 pends: req0 goes first.
        set_req(1, 24'h000300, 16'd1);
        set_req(0, 24'h000400, 16'd0);
        push_read(1, 24'h000300, 16'd1, -1);
        push_read(0, 24'h000400, 16'd0, -1);
        push_read(1, 24'h000300, 16'd1, -1);
        rem[1] = 1;
        req_valid[1] = 1'b1;
        repeat (3) tick();
        rem[0] = 1;
        req_valid[0] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (req_done[1]) got = 1'b1;
        end
        check("saw_done1", 64'(got), 64'd1);
        rem[1] = 1;
        req_valid[1] = 1'b1;
        drain("no_monopoly", 120);

        // req1 withdraws before it could be granted.
        set_req(0, 24'h000500, 16'd3);
        set_req(1, 24'h000700, 16'd3);
        push_read(0, 24'h000500, 16'd3, -1);
        rem[0] = 1;
        req_valid[0] = 1'b1;
        repeat (3) tick();
        req_valid[1] = 1'b1;
        repeat (2) tick();
        req_valid[1] = 1'b0;
        drain("withdraw", 60);

`ifdef SPI_FLASH_ARB_CHECK_EN
        check("err_clean", 64'(err), 64'd0);
        set_req(0, 24'h000600, 16'd7);
        push_read(0, 24'h000600, 16'd7, 3);
        drop_idx = 3;
        rem[0] = 1;
        req_valid[0] = 1'b1;
        drain("dropped_byte", 60);
        drop_idx = -1;
        check("err_set", 64'(err), 64'd1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
